// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// halt encoding, branch opcode and the absolute branch target table used
// when BRANCH_LUT_EN is defined.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [8:0] HALT_INSTR_DEF = 9'b111_111_111;
    localparam logic [2:0] OPC_BRANCH     = 3'b111;

    // Absolute branch targets, indexed by instruction[2:0]. Entries are
    // 16 bits wide and truncated to the PC width at the point of use.
    localparam logic [15:0] BRANCH_LUT [0:7] = '{
        16'h000, 16'h004, 16'h010, 16'h040,
        16'h080, 16'h100, 16'h020, 16'h3F8
    };

    // Opcode field is the top three bits of the 9-bit instruction word.
    function automatic logic is_branch(input logic [8:0] instr);
        return instr[8:6] == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: control inputs, instruction memory port, the registered
// instruction handed to the decoder, and the FSM state for observation.
//
// Handshake: the word on instruction/instr_pc is handed downstream on every
// rising edge where instr_valid=1 and stall=0. While stall=1 the fetch unit
// keeps instruction, instr_pc and instr_valid stable. branch_taken is only
// meaningful on an edge where the handoff happens.
interface inst_fetch_if #(
    parameter int PC_W = 10
);
    import inst_fetch_pkg::*;

    logic            start;
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_data;
    logic [8:0]      instruction;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            done;
    fetch_state_e    state_dbg;

    // Environment side: drives control and the memory read data.
    modport master (
        output start, stall, branch_taken, imem_data,
        input  imem_addr, instruction, instr_pc, instr_valid, done, state_dbg
    );

    // Fetch unit side.
    modport slave (
        input  start, stall, branch_taken, imem_data,
        output imem_addr, instruction, instr_pc, instr_valid, done, state_dbg
    );

endinterface

// File: rtl/inst_fetch_branch_target.sv
// Combinational branch target for the instruction currently held in the
// fetch register. Macro BRANCH_LUT_EN selects an absolute table lookup;
// otherwise the target is instr_pc plus the sign-extended 6-bit offset.
// PC_W is expected to be between 6 and 16.
module branch_target
    import inst_fetch_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [8:0]      instruction,
    input  logic [PC_W-1:0] instr_pc,
    output logic [PC_W-1:0] target
);

`ifdef BRANCH_LUT_EN
    logic unused_bits;
    assign unused_bits = ^{instruction[8:3], instr_pc};

    // Absolute target picked from the constant table.
    always_comb begin
        target = BRANCH_LUT[instruction[2:0]][PC_W-1:0];
    end
`else
    logic [PC_W-1:0] offset_ext;
    logic            unused_bits;
    assign unused_bits = ^instruction[8:6];

    // Relative target; the adder wraps naturally modulo 2^PC_W.
    always_comb begin
        offset_ext = {{(PC_W-6){instruction[5]}}, instruction[5:0]};
        target     = instr_pc + offset_ext;
    end
`endif

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: IDLE/RUN/HALT sequencer with a one-word fetch
// register. Branch target form is selected by the BRANCH_LUT_EN macro
// (see branch_target). Memory read is combinational on imem_addr == pc.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int         PC_W       = 10,
    parameter logic [8:0] HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.slave  bus
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ipc_q, ipc_d;
    logic [8:0]      instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] target;

    branch_target #(
        .PC_W (PC_W)
    ) u_branch_target (
        .instruction (instr_q),
        .instr_pc    (ipc_q),
        .target      (target)
    );

    // Register all fetch state; asynchronous reset returns to IDLE at pc 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ipc_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and datapath: stall freezes everything in RUN, halt beats
    // branch, and a taken branch squashes the word at pc for one cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                pc_d    = '0;
                valid_d = 1'b0;
                if (bus.start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    if (valid_q && (instr_q == HALT_INSTR)) begin
                        state_d = ST_HALT;
                        valid_d = 1'b0;
                    end else if (valid_q && bus.branch_taken) begin
                        pc_d    = target;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = bus.imem_data;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_W'(1);
                    end
                end
            end
            ST_HALT: begin
                valid_d = 1'b0;
                if (bus.start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instruction = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_valid = valid_q;
    assign bus.done        = (state_q == ST_HALT);
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a directed vector table, hand-written
// branch/halt/wrap/reset sequences, and a randomized run compared against a
// cycle-level reference model plus an expected-handoff queue.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int         PC_W   = 10;
    localparam int         DEPTH  = 1 << PC_W;
    localparam logic [8:0] HALT_W = 9'h1FF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    inst_fetch_if #(.PC_W(PC_W)) bus ();

    inst_fetch #(
        .PC_W       (PC_W),
        .HALT_INSTR (HALT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / memory ----------------
    always #5 clk = ~clk;

    logic [8:0] imem [0:DEPTH-1];
    assign bus.imem_data = imem[bus.imem_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [PC_W+8:0] exp_q[$];

    // Reference model: mode 0=idle, 1=run, 2=halt.
    int         m_mode;
    int         m_pc;
    int         m_ipc;
    logic [8:0] m_instr;
    logic       m_valid;
    int         tb_lut [8] = '{0, 4, 16, 64, 128, 256, 32, 1016};

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_target();
`ifdef BRANCH_LUT_EN
        return tb_lut[m_instr[2:0]];
`else
        int off;
        off = m_instr[5] ? (int'(m_instr[5:0]) - 64) : int'(m_instr[5:0]);
        return (m_ipc + off + DEPTH) % DEPTH;
`endif
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_ipc   = 0;
        m_instr = '0;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        case (m_mode)
            0: if (bus.start) m_mode = 1;
            1: if (!bus.stall) begin
                if (m_valid) exp_q.push_back({PC_W'(m_ipc), m_instr});
                if (m_valid && m_instr == HALT_W) begin
                    m_mode  = 2;
                    m_valid = 1'b0;
                end else if (m_valid && bus.branch_taken) begin
                    m_pc    = model_target();
                    m_valid = 1'b0;
                end else begin
                    m_instr = imem[m_pc];
                    m_ipc   = m_pc;
                    m_valid = 1'b1;
                    m_pc    = (m_pc + 1) % DEPTH;
                end
            end
            default: if (bus.start) begin
                m_mode = 1;
                m_pc   = 0;
            end
        endcase
    endtask

    task automatic check_model();
        logic [30:0] act, exp;
        act = {bus.imem_addr, bus.instruction, bus.instr_pc, bus.instr_valid, bus.done};
        exp = {PC_W'(m_pc), m_instr, PC_W'(m_ipc), m_valid, (m_mode == 2)};
        check_val("model_outputs", 64'(act), 64'(exp));
    endtask

    task automatic expect_out(input string name, input logic v, input int ipc,
                              input logic [8:0] instr, input int addr, input logic dn);
        logic [30:0] act, exp;
        act = {bus.imem_addr, bus.instruction, bus.instr_pc, bus.instr_valid, bus.done};
        exp = {PC_W'(addr), instr, PC_W'(ipc), v, dn};
        check_val(name, 64'(act), 64'(exp));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic s, input logic st, input logic bt);
        bus.start        = s;
        bus.stall        = st;
        bus.branch_taken = bt;
    endtask

    // One clock: note the handoff seen by the DUT, step the model, compare.
    task automatic cycle();
        logic            consumed;
        logic [PC_W+8:0] act_pair;
        logic [PC_W+8:0] exp_pair;
        consumed = bus.instr_valid && !bus.stall;
        act_pair = {bus.instr_pc, bus.instruction};
        @(posedge clk);
        model_step();
        #1;
        check_model();
        if (consumed) begin
            check_val("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                exp_pair = exp_q.pop_front();
                check_val("handoff", 64'(act_pair), 64'(exp_pair));
            end
        end
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int k = 0; k < DEPTH; k++) imem[k] = 9'h000;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       start;
        logic       stall;
        logic       bt;
        logic       exp_valid;
        int         exp_ipc;
        logic [8:0] exp_instr;
        int         exp_addr;
    } vec_t;

    vec_t vecs [10];

    // ---------------- test sequence ----------------
    initial begin
        int         tgt;
        logic [8:0] br_word;
        logic       found;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 9'h000, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 9'h001, 1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 9'h002, 2};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 9'h003, 3};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 9'h003, 3};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 9'h003, 3};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 9'h003, 3};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 9'h004, 4};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 4, 9'h005, 5};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 5, 9'h006, 6};

        // Reset state and linear fetch with stall.
        clear_mem();
        for (int k = 0; k < 8; k++) imem[k] = 9'(k + 1);
        do_reset();
        expect_out("reset_outputs", 1'b0, 0, 9'h000, 0, 1'b0);
        check_val("reset_state", 64'(bus.state_dbg), 64'(ST_IDLE));
        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].start, vecs[i].stall, vecs[i].bt);
            cycle();
            expect_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ipc,
                       vecs[i].exp_instr, vecs[i].exp_addr, 1'b0);
        end
        set_in(1'b0, 1'b0, 1'b0);

        // Branch at address 4 with one-cycle squash; branch_taken held
        // through the bubble to show it is ignored while instr_valid=0.
`ifdef BRANCH_LUT_EN
        br_word = 9'h1C6;
        tgt     = 32;
`else
        br_word = 9'h1FE;
        tgt     = 2;
`endif
        clear_mem();
        for (int k = 0; k < 64; k++) imem[k] = 9'(16 + k);
        imem[4] = br_word;
        do_reset();
        set_in(1'b1, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 1'b0);
        repeat (5) cycle();
        expect_out("branch_at4", 1'b1, 4, br_word, 5, 1'b0);
        set_in(1'b0, 1'b0, 1'b1);
        cycle();
        expect_out("branch_bubble", 1'b0, 4, br_word, tgt, 1'b0);
        cycle();
        expect_out("branch_resume", 1'b1, tgt, 9'(16 + tgt), tgt + 1, 1'b0);
        set_in(1'b0, 1'b0, 1'b0);
        cycle();

        // Halt at address 7 together with branch_taken, then restart.
        clear_mem();
        for (int k = 0; k < 16; k++) imem[k] = 9'(32 + k);
        imem[7] = HALT_W;
        do_reset();
        set_in(1'b1, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 1'b0);
        repeat (8) cycle();
        expect_out("halt_word", 1'b1, 7, HALT_W, 8, 1'b0);
        set_in(1'b0, 1'b0, 1'b1);
        cycle();
        expect_out("halt_enter", 1'b0, 7, HALT_W, 8, 1'b1);
        set_in(1'b0, 1'b0, 1'b0);
        repeat (2) cycle();
        expect_out("halt_frozen", 1'b0, 7, HALT_W, 8, 1'b1);
        set_in(1'b1, 1'b0, 1'b0);
        cycle();
        expect_out("halt_restart", 1'b0, 7, HALT_W, 0, 1'b0);
        set_in(1'b0, 1'b0, 1'b0);
        cycle();
        expect_out("restart_fetch0", 1'b1, 0, 9'h020, 1, 1'b0);

        // PC wrap from 2^PC_W-1 to 0.
        for (int k = 0; k < DEPTH; k++) imem[k] = 9'(k & 255);
        do_reset();
        set_in(1'b1, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 1'b0);
        found = 1'b0;
        for (int n = 0; n < DEPTH + 20 && !found; n++) begin
            cycle();
            if (bus.instr_valid && bus.instr_pc == PC_W'(DEPTH - 1)) found = 1'b1;
        end
        check_val("wrap_reached", 64'(found), 64'd1);
        cycle();
        expect_out("wrap_to_zero", 1'b1, 0, 9'h000, 1, 1'b0);

        // Asynchronous reset between edges in the middle of RUN; start held
        // during reset must not launch a run.
        for (int k = 0; k < 16; k++) imem[k] = 9'(64 + k);
        do_reset();
        set_in(1'b1, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 1'b0);
        repeat (5) cycle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        expect_out("async_reset_outputs", 1'b0, 0, 9'h000, 0, 1'b0);
        check_val("async_reset_state", 64'(bus.state_dbg), 64'(ST_IDLE));
        set_in(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_val("start_in_reset", 64'(bus.state_dbg), 64'(ST_IDLE));
        set_in(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();
        check_val("idle_after_reset", 64'(bus.instr_valid), 64'd0);
        set_in(1'b1, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 1'b0);
        cycle();
        expect_out("post_reset_fetch", 1'b1, 0, 9'h040, 1, 1'b0);

        // Randomized run against the reference model.
        for (int k = 0; k < DEPTH; k++) begin
            imem[k] = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 63) == 0) imem[k] = HALT_W;
        end
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 2) == 0));
            cycle();
        end
        set_in(1'b0, 1'b0, 1'b0);

        check_val("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
